// File: rtl/bnn_feat_loader.sv
// bnn_feat_loader: streams features into a flat classifier word, captures the class and hands it downstream.
module bnn_feat_loader #(
  parameter int N = 11,
  parameter int B = 4,
  parameter int C = 6,
  localparam int KW = $clog2(C)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          feat_valid,
  output logic          feat_ready,
  input  logic [B-1:0]  feat_data,
  input  logic          feat_last,
  output logic [N*B-1:0] inp,
  input  logic [KW-1:0] klass_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [KW-1:0] res_klass,
  output logic [7:0]    res_idx,
  output logic          err
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {LOAD, EVAL, OUT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic beat, full;
  assign feat_ready = state == LOAD;
  assign beat = feat_valid & feat_ready;
  assign full = cnt == CW'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (beat && full) ? EVAL :
               (state == EVAL) ? OUT :
               (state == OUT && res_ready) ? LOAD : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inp <= '0;
      cnt <= '0;
      res_valid <= 1'b0;
      res_klass <= '0;
      res_idx <= '0;
      err <= 1'b0;
    end else begin
      if (beat) begin
        inp <= {inp[N*B-B-1:0], feat_data};
        cnt <= (full || feat_last) ? '0 : cnt + 1'b1;
        if (full != feat_last) err <= 1'b1;
      end
      if (state == EVAL) begin
        res_klass <= klass_in;
        res_valid <= 1'b1;
      end
      if (state == OUT && res_ready) begin
        res_valid <= 1'b0;
        res_idx <= res_idx + 8'd1;
      end
    end
endmodule

// File: tb/tb_bnn_feat_loader.sv
// tb_bnn_feat_loader: directed checks of beat assembly, handshake, framing errors, reset and index wrap.
module tb_bnn_feat_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic feat_valid = 1'b0, feat_last = 1'b0, res_ready = 1'b0;
  logic [3:0] feat_data = '0;
  logic [2:0] klass_in = '0;
  logic feat_ready, res_valid, err;
  logic [43:0] inp;
  logic [2:0] res_klass;
  logic [7:0] res_idx;
  int checks = 0, errors = 0;
  logic [43:0] w;
  logic [7:0] idx;
  time t_prev;

  bnn_feat_loader dut (
    .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .feat_last(feat_last), .inp(inp), .klass_in(klass_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_klass(res_klass),
    .res_idx(res_idx), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    feat_valid = 1'b1;
    feat_data = d;
    feat_last = last;
    step();
    feat_valid = 1'b0;
    feat_last = 1'b0;
  endtask

  task automatic feed(input logic [43:0] word, input int nb, input logic last);
    for (int i = 0; i < nb; i++) send(word[43-4*i -: 4], last && i == nb - 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inp", 64'(inp), 0);
    chk("rst_valid", 64'(res_valid), 0);
    chk("rst_klass", 64'(res_klass), 0);
    chk("rst_idx", 64'(res_idx), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_ready", 64'(feat_ready), 1);
    rst = 1'b0;

    klass_in = 3'd3;
    res_ready = 1'b1;
    feed(44'h46012229a22, 11, 1'b1);
    chk("t1_eval_inp", 64'(inp), 64'h46012229a22);
    chk("t1_eval_ready", 64'(feat_ready), 0);
    chk("t1_eval_valid", 64'(res_valid), 0);
    step();
    chk("t1_valid", 64'(res_valid), 1);
    chk("t1_klass", 64'(res_klass), 3);
    chk("t1_idx", 64'(res_idx), 0);
    step();
    chk("t1_done_valid", 64'(res_valid), 0);
    chk("t1_done_idx", 64'(res_idx), 1);
    chk("t1_done_ready", 64'(feat_ready), 1);
    chk("t1_err", 64'(err), 0);

    klass_in = 3'd5;
    res_ready = 1'b0;
    feed(44'h46012229a22, 11, 1'b1);
    step();
    feat_valid = 1'b1;
    feat_data = 4'hf;
    feat_last = 1'b1;
    klass_in = 3'd1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 64'(res_valid), 1);
      chk("t2_klass", 64'(res_klass), 5);
      chk("t2_idx", 64'(res_idx), 1);
      chk("t2_inp", 64'(inp), 64'h46012229a22);
      chk("t2_ready", 64'(feat_ready), 0);
      step();
    end
    feat_valid = 1'b0;
    feat_last = 1'b0;
    res_ready = 1'b1;
    step();
    chk("t2_done_valid", 64'(res_valid), 0);
    chk("t2_done_idx", 64'(res_idx), 2);
    chk("t2_done_ready", 64'(feat_ready), 1);
    chk("t2_inp_kept", 64'(inp), 64'h46012229a22);

    idx = 8'd2;
    for (int k = 0; k < 256; k++) begin
      w = {12'($urandom), 32'($urandom)};
      klass_in = 3'(k % 6);
      feed(w, 11, 1'b1);
      chk("bb_inp", 64'(inp), 64'(w));
      step();
      chk("bb_valid", 64'(res_valid), 1);
      chk("bb_klass", 64'(res_klass), 64'(k % 6));
      chk("bb_idx", 64'(res_idx), 64'(idx));
      if (k > 0) chk("bb_period", 64'($time - t_prev), 130);
      t_prev = $time;
      idx = idx + 8'd1;
      step();
      chk("bb_low", 64'(res_valid), 0);
    end
    chk("bb_wrap_idx", 64'(res_idx), 2);
    chk("bb_err", 64'(err), 0);

    klass_in = 3'd2;
    feed(44'h58020000000, 4, 1'b1);
    chk("t3_err", 64'(err), 1);
    chk("t3_ready", 64'(feat_ready), 1);
    chk("t3_inp", 64'(inp), 64'({w[27:0], 16'h5802}));
    step();
    step();
    chk("t3_novalid", 64'(res_valid), 0);
    feed(44'h57122338733, 11, 1'b1);
    chk("t3_inp_full", 64'(inp), 64'h57122338733);
    step();
    chk("t3_valid", 64'(res_valid), 1);
    chk("t3_klass", 64'(res_klass), 2);
    chk("t3_idx", 64'(res_idx), 2);
    step();
    chk("t3_err_sticky", 64'(err), 1);

    klass_in = 3'd4;
    feed(44'h0123456789a, 11, 1'b0);
    chk("t4_inp", 64'(inp), 64'h0123456789a);
    step();
    chk("t4_valid", 64'(res_valid), 1);
    chk("t4_klass", 64'(res_klass), 4);
    step();
    chk("t4_err", 64'(err), 1);
    chk("t4_idx", 64'(res_idx), 4);

    feed(44'h12345600000, 6, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_inp", 64'(inp), 0);
    chk("t5_valid", 64'(res_valid), 0);
    chk("t5_err", 64'(err), 0);
    chk("t5_idx", 64'(res_idx), 0);
    chk("t5_ready", 64'(feat_ready), 1);
    rst = 1'b0;
    klass_in = 3'd1;
    feed(44'h92912439523, 11, 1'b1);
    chk("t5_inp_full", 64'(inp), 64'h92912439523);
    chk("t5_eval_ready", 64'(feat_ready), 0);
    step();
    chk("t5_valid", 64'(res_valid), 1);
    chk("t5_klass", 64'(res_klass), 1);
    chk("t5_res_idx", 64'(res_idx), 0);
    step();
    chk("t5_idx_next", 64'(res_idx), 1);
    chk("t5_err_end", 64'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
